// File: rtl/station_dispatch.sv
`default_nettype none
// ============================================================================
//  Module      : station_dispatch
//  Description : In-order iop buffer between decode and the reservation
//                station pool. Each cycle the FIFO head is handed to at most
//                one free station. The station is chosen round-robin,
//                scanning upward from the station after the last one fed.
//
//  Ports       : clk, a_rst (sync, active-high)
//                dec_valid/dec_ready/dec_iop/dec_iop_init/dec_pc/dec_k16
//                                     - decode handshake and iop payload
//                flush                - drop every buffered iop
//                st_complete          - per-station free (id_complete)
//                st_feed              - one-hot feed strobe (0 or 1 bit set)
//                st_iop/st_iop_init/st_pc/st_k16
//                                     - payload broadcast to all stations
//                fifo_count           - occupied FIFO entries
//
//  Options     : DISPATCH_BYPASS_EN - when the FIFO is empty, the decode
//                payload goes straight to a free station in the same cycle.
//
//  Revision    : 1.0 - initial release
// ============================================================================
module station_dispatch #(
    parameter int STATIONS = 4,
    parameter int DEPTH    = 4,
    parameter int CW       = 3
) (
    input  logic                clk,
    input  logic                a_rst,
    input  logic                dec_valid,
    output logic                dec_ready,
    input  logic [31:0]         dec_iop,
    input  logic [2:0]          dec_iop_init,
    input  logic [15:0]         dec_pc,
    input  logic [15:0]         dec_k16,
    input  logic                flush,
    input  logic [STATIONS-1:0] st_complete,
    output logic [STATIONS-1:0] st_feed,
    output logic [31:0]         st_iop,
    output logic [2:0]          st_iop_init,
    output logic [15:0]         st_pc,
    output logic [15:0]         st_k16,
    output logic [CW-1:0]       fifo_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SW = (STATIONS > 1) ? $clog2(STATIONS) : 1;
    localparam int DW = 32 + 3 + 16 + 16;

    localparam logic [CW-1:0] c_full_count = CW'(DEPTH);
    localparam logic [CW-1:0] c_count_one  = CW'(1);
    localparam logic [AW-1:0] c_ptr_one    = AW'(1);
    localparam logic [SW:0]   c_stations   = (SW+1)'(STATIONS);
    localparam logic [SW-1:0] c_last_st    = SW'(STATIONS - 1);
    localparam logic [SW-1:0] c_st_one     = SW'(1);

    logic [DW-1:0]  r_mem [DEPTH];
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [CW-1:0]  r_count;
    logic [SW-1:0]  r_rr_ptr;

    logic           w_full;
    logic           w_empty;
    logic           w_any_free;
    logic           w_dispatch;
    logic           w_bypass;
    logic           w_push;
    logic           w_pop;
    logic [SW-1:0]  w_sel;
    logic           w_found;
    logic [SW:0]    w_cand;
    logic [DW-1:0]  w_head;
    logic [DW-1:0]  w_dec_word;
    logic [DW-1:0]  w_out_word;

    assign w_full     = (r_count == c_full_count);
    assign w_empty    = (r_count == '0);
    assign w_any_free = |st_complete;
    assign w_head     = r_mem[r_rd_ptr];
    assign w_dec_word = {dec_iop, dec_iop_init, dec_pc, dec_k16};

    // A full FIFO refuses input even if it pops this cycle; this keeps
    // dec_ready independent of st_complete.
    assign dec_ready  = ~w_full & ~flush & ~a_rst;

    assign w_dispatch = ~w_empty & ~flush & ~a_rst & w_any_free;
    assign w_pop      = w_dispatch;

`ifdef DISPATCH_BYPASS_EN
    // An empty FIFO lets the decode payload pass directly to a free
    // station; that iop is consumed without ever occupying an entry.
    assign w_bypass = w_empty & ~flush & ~a_rst & dec_valid & w_any_free;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_push = dec_valid & dec_ready & ~w_bypass;

    // Round-robin scan: candidate = (rr_ptr + i) mod STATIONS. rr_ptr is
    // always below STATIONS, so a single conditional subtract wraps it.
    always_comb begin
        w_found = 1'b0;
        w_sel   = r_rr_ptr;
        w_cand  = '0;
        for (int i = 0; i < STATIONS; i++) begin
            w_cand = {1'b0, r_rr_ptr} + (SW+1)'(i);
            if (w_cand >= c_stations) begin
                w_cand = w_cand - c_stations;
            end
            if (!w_found && st_complete[w_cand[SW-1:0]]) begin
                w_found = 1'b1;
                w_sel   = w_cand[SW-1:0];
            end
        end
    end

    always_comb begin
        st_feed = '0;
        if (w_dispatch || w_bypass) begin
            st_feed[w_sel] = 1'b1;
        end
    end

    assign w_out_word = w_bypass ? w_dec_word : w_head;
    assign {st_iop, st_iop_init, st_pc, st_k16} = w_out_word;
    assign fifo_count = r_count;

    // Storage is not reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_dec_word;
        end
    end

    always_ff @(posedge clk) begin
        if (a_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_rr_ptr <= '0;
        end else if (flush) begin
            // The round-robin position deliberately survives a flush.
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_count_one;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - c_count_one;
            end
            if (w_dispatch || w_bypass) begin
                r_rr_ptr <= (w_sel == c_last_st) ? '0 : (w_sel + c_st_one);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_station_dispatch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_station_dispatch
//  Description : Directed bench for station_dispatch. A queue-based model
//                predicts dec_ready, fifo_count, st_feed and the broadcast
//                payload every cycle; literal expectations pin key scenarios.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_station_dispatch;

    localparam int STATIONS = 4;
    localparam int DEPTH    = 4;
    localparam int CW       = 3;
`ifdef DISPATCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                a_rst = 1'b1;
    logic                dec_valid = 1'b0;
    logic                dec_ready;
    logic [31:0]         dec_iop = '0;
    logic [2:0]          dec_iop_init = '0;
    logic [15:0]         dec_pc = '0;
    logic [15:0]         dec_k16 = '0;
    logic                flush = 1'b0;
    logic [STATIONS-1:0] st_complete = '0;
    logic [STATIONS-1:0] st_feed;
    logic [31:0]         st_iop;
    logic [2:0]          st_iop_init;
    logic [15:0]         st_pc;
    logic [15:0]         st_k16;
    logic [CW-1:0]       fifo_count;

    int n_vec = 0;
    int n_mis = 0;

    station_dispatch #(.STATIONS(STATIONS), .DEPTH(DEPTH), .CW(CW)) dut (
        .clk          (clk),
        .a_rst        (a_rst),
        .dec_valid    (dec_valid),
        .dec_ready    (dec_ready),
        .dec_iop      (dec_iop),
        .dec_iop_init (dec_iop_init),
        .dec_pc       (dec_pc),
        .dec_k16      (dec_k16),
        .flush        (flush),
        .st_complete  (st_complete),
        .st_feed      (st_feed),
        .st_iop       (st_iop),
        .st_iop_init  (st_iop_init),
        .st_pc        (st_pc),
        .st_k16       (st_k16),
        .fifo_count   (fifo_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [66:0] q[$];
    int          rr = 0;

    always @(negedge clk) begin
        logic [STATIONS-1:0] ef;
        logic [66:0]         ed;
        bit                  er;
        bit                  disp;
        bit                  from_q;
        int                  ch;
        int                  s;
        er     = (q.size() < DEPTH) && !flush && !a_rst;
        ef     = '0;
        ed     = '0;
        disp   = 1'b0;
        from_q = 1'b0;
        ch     = 0;
        if (!a_rst && !flush && (|st_complete) &&
            (q.size() > 0 || (BYP && dec_valid))) begin
            disp = 1'b1;
            for (int j = STATIONS - 1; j >= 0; j--) begin
                s = (rr + j) % STATIONS;
                if (st_complete[s]) ch = s;
            end
            ef[ch] = 1'b1;
            if (q.size() > 0) begin
                from_q = 1'b1;
                ed = q[0];
            end else begin
                ed = {dec_iop, dec_iop_init, dec_pc, dec_k16};
            end
        end
        chk("dec_ready", dec_ready, er);
        chk("fifo_count", fifo_count, q.size());
        chk("st_feed", st_feed, ef);
        if (disp) chk("st_payload", {st_iop, st_iop_init, st_pc, st_k16}, ed);

        if (a_rst) begin
            q.delete();
            rr = 0;
        end else if (flush) begin
            q.delete();
        end else begin
            if (disp) begin
                if (from_q) void'(q.pop_front());
                rr = (ch + 1) % STATIONS;
            end
            if (dec_valid && er && (from_q || !disp))
                q.push_back({dec_iop, dec_iop_init, dec_pc, dec_k16});
        end
    end

    // ---------------- stimulus ----------------
    task automatic drv(input bit rst, input bit fl, input bit v, input logic [31:0] iop,
                       input logic [2:0] ini, input logic [15:0] pc, input logic [3:0] comp);
        @(posedge clk);
        #1;
        a_rst        = rst;
        flush        = fl;
        dec_valid    = v;
        dec_iop      = iop;
        dec_iop_init = ini;
        dec_pc       = pc;
        dec_k16      = ~pc;
        st_complete  = comp;
    endtask

    logic [3:0] rr_exp [5];

    initial begin
        rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0100;
        rr_exp[3] = 4'b1000; rr_exp[4] = 4'b0001;

        drv(1, 0, 0, 0, 0, 0, 4'h0);
        drv(1, 0, 1, 32'hDEAD, 0, 0, 4'hF);
        @(negedge clk);
        chk("reset_feed", st_feed, 4'b0000);
        chk("reset_ready", dec_ready, 1'b0);
        chk("reset_count", fifo_count, 3'd0);

        // single iop, all stations free
        drv(0, 0, 1, 32'h00A1B2C3, 3'd5, 16'h1234, 4'hF);
        drv(0, 0, 0, 0, 0, 0, 4'hF);
        @(negedge clk);
`ifndef DISPATCH_BYPASS_EN
        chk("t1_feed", st_feed, 4'b0001);
        chk("t1_pc", st_pc, 16'h1234);
        chk("t1_iop", st_iop, 32'h00A1B2C3);
        chk("t1_count_before", fifo_count, 3'd1);
`endif
        drv(0, 0, 0, 0, 0, 0, 4'hF);
        @(negedge clk);
        chk("t1_count_after", fifo_count, 3'd0);

        // fill with no free station; 5th offer refused
        for (int k = 0; k < 5; k++) begin
            drv(0, 0, 1, 32'h100 + k, 3'(k), 16'h0100 + 16'(k), 4'h0);
            @(negedge clk);
            if (k == 4) begin
                chk("t2_ready_full", dec_ready, 1'b0);
                chk("t2_count_full", fifo_count, 3'd4);
            end
        end
        drv(0, 0, 0, 0, 0, 0, 4'b0100);
        @(negedge clk);
        chk("t2_feed", st_feed, 4'b0100);
        chk("t2_head_init000", st_iop_init, 3'd0);
        drv(0, 0, 0, 0, 0, 0, 4'h0);
        @(negedge clk);
        chk("t2_ready_after", dec_ready, 1'b1);
        chk("t2_count_after", fifo_count, 3'd3);

        // round-robin from a fresh reset
        drv(1, 0, 0, 0, 0, 0, 4'h0);
        for (int k = 0; k < 6; k++) begin
            drv(0, 0, k < 5, 32'h200 + k, 3'd1, 16'h0200 + 16'(k), 4'hF);
            @(negedge clk);
`ifndef DISPATCH_BYPASS_EN
            if (k > 0) chk("t3_rr_feed", st_feed, rr_exp[k-1]);
`endif
        end

        // flush with three buffered, round-robin position kept (next = 1)
        for (int k = 0; k < 3; k++) begin
            drv(0, 0, 1, 32'h300 + k, 3'd2, 16'h0300 + 16'(k), 4'h0);
        end
        drv(0, 1, 1, 32'h3FF, 3'd2, 16'h03FF, 4'hF);
        @(negedge clk);
        chk("t4_flush_feed", st_feed, 4'b0000);
        chk("t4_flush_ready", dec_ready, 1'b0);
        chk("t4_flush_count", fifo_count, 3'd3);
        drv(0, 0, 1, 32'h310, 3'd3, 16'h0310, 4'hF);
        @(negedge clk);
        chk("t4_count_zero", fifo_count, 3'd0);
`ifndef DISPATCH_BYPASS_EN
        chk("t4_no_feed_empty", st_feed, 4'b0000);
        drv(0, 0, 0, 0, 0, 0, 4'hF);
        @(negedge clk);
        chk("t4_rr_kept", st_feed, 4'b0010);
        chk("t4_pc", st_pc, 16'h0310);
`endif

        // reset mid-burst (together with flush)
        drv(0, 0, 1, 32'h400, 3'd4, 16'h0400, 4'h0);
        drv(0, 0, 1, 32'h401, 3'd4, 16'h0401, 4'h0);
        drv(1, 1, 1, 32'h402, 3'd4, 16'h0402, 4'hF);
        @(negedge clk);
        chk("t5_rst_feed", st_feed, 4'b0000);
        chk("t5_rst_ready", dec_ready, 1'b0);
        drv(0, 0, 0, 0, 0, 0, 4'h0);
        @(negedge clk);
        chk("t5_count", fifo_count, 3'd0);

`ifdef DISPATCH_BYPASS_EN
        // empty FIFO, station 1 free: same-cycle feed, nothing buffered
        drv(0, 0, 1, 32'h500, 3'd6, 16'h0500, 4'b0010);
        @(negedge clk);
        chk("t6_byp_feed", st_feed, 4'b0010);
        chk("t6_byp_pc", st_pc, 16'h0500);
        drv(0, 0, 0, 0, 0, 0, 4'b0000);
        @(negedge clk);
        chk("t6_byp_count", fifo_count, 3'd0);
`endif

        // mixed traffic, checked by the model every cycle
        for (int k = 0; k < 300; k++) begin
            drv(($urandom % 64) == 0, ($urandom % 40) == 0, 1'($urandom),
                $urandom, 3'($urandom), 16'($urandom), 4'($urandom));
        end
        drv(0, 0, 0, 0, 0, 0, 4'h0);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
